// File: rtl/htif_host_responder.sv
// Host-side tohost/fromhost mailbox responder: decodes tohost words, services
// console putchar through a byte FIFO, answers with fromhost words and latches
// the program exit code.
module htif_host_responder #(
  parameter int unsigned ACK_DELAY  = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tohost_valid,
  input  logic [63:0] tohost_data,
  output logic        tohost_ready,
  output logic        fromhost_valid,
  output logic [63:0] fromhost_data,
  input  logic        fromhost_ready,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        done,
  output logic [62:0] exit_code,
  output logic        err_unknown
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned DlyW = (ACK_DELAY > 0) ? $clog2(ACK_DELAY + 1) : 1;

  typedef enum logic [2:0] {
    StIdle, StDecode, StDelay, StResp, StDrain, StHalt
  } state_e;

  state_e             state_q, state_d;
  logic [63:0]        word_q, word_d;
  logic [47:0]        resp_q, resp_d;
  logic [DlyW-1:0]    dly_q, dly_d;
  logic [62:0]        exit_q, exit_d;
  logic               err_q, err_d;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]      count_q;

  logic               push, pop, ack;
  logic               fifo_full, fifo_empty;
  logic               is_exit, is_putc, is_getc;
  logic [7:0]         dev, cmd;

  assign dev        = word_q[63:56];
  assign cmd        = word_q[55:48];
  assign is_exit    = word_q[0] && (dev == 8'd0) && (cmd == 8'd0);
  assign is_putc    = (dev == 8'd1) && (cmd == 8'd1);
  assign is_getc    = (dev == 8'd1) && (cmd == 8'd0);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (PtrW+1)'(FIFO_DEPTH));
  assign pop        = char_ready && !fifo_empty;

  // Next-state and decode logic for the mailbox FSM.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    resp_d  = resp_q;
    dly_d   = dly_q;
    exit_d  = exit_q;
    err_d   = err_q;
    push    = 1'b0;
    ack     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A zero word is a no-op poll: accepted and dropped.
        if (tohost_valid && (tohost_data != 64'd0)) begin
          word_d  = tohost_data;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_exit) begin
          exit_d  = word_q[63:1];
          state_d = StDrain;
        end else if (is_putc) begin
          // Stall here while the FIFO is full.
          if (!fifo_full) begin
            push   = 1'b1;
            resp_d = 48'd0;
            ack    = 1'b1;
          end
        end else if (is_getc) begin
          resp_d = '1;  // EOF: no input source behind the console
          ack    = 1'b1;
        end else begin
          err_d  = 1'b1;
          resp_d = 48'd1;
          ack    = 1'b1;
        end
        if (ack) begin
          dly_d   = DlyW'(ACK_DELAY);
          state_d = (ACK_DELAY == 0) ? StResp : StDelay;
        end
      end
      StDelay: begin
        if (dly_q <= DlyW'(1)) state_d = StResp;
        else                   dly_d   = dly_q - DlyW'(1);
      end
      StResp: begin
        if (fromhost_ready) state_d = StIdle;
      end
      StDrain: begin
        if (fifo_empty) state_d = StHalt;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      word_q  <= '0;
      resp_q  <= '0;
      dly_q   <= '0;
      exit_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      resp_q  <= resp_d;
      dly_q   <= dly_d;
      exit_q  <= exit_d;
      err_q   <= err_d;
    end
  end

  // FIFO pointers and occupancy; the count has one extra bit to tell full from empty.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are only visible while occupied, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= word_q[7:0];
  end

  assign tohost_ready   = (state_q == StIdle);
  assign fromhost_valid = (state_q == StResp);
  assign fromhost_data  = fromhost_valid ? {word_q[63:48], resp_q} : 64'd0;
  assign char_valid     = !fifo_empty;
  assign char_data      = fifo_empty ? 8'd0 : mem_q[rd_ptr_q];
  assign done           = (state_q == StHalt);
  assign exit_code      = exit_q;
  assign err_unknown    = err_q;

endmodule
